in_port_arbiter: RTL and testbench
==================================

IN_PORT_ARBITER -- requirements
Module: in_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, CPU IN wait limit in clock cycles, only used with the timeout feature, legal range 2..2^24.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_req  input  1  CPU IN request level; held high until in_ack is seen.
REQ-005 in_ack  output  1  one-cycle registered pulse; in_data/in_src valid in that cycle.
REQ-006 in_data  output  32  word delivered to CPU.
REQ-007 in_src  output  2  source of the delivered word: 0 switches, 1 UART, 2 link, 3 timeout.
REQ-008 in_on  output  1  high while the CPU is waiting (state WAIT).
REQ-009 sw_pulse  input  1  one-cycle pulse from the input-button oneshot.
REQ-010 sw_data  input  16  switch value.
REQ-011 sw_unsigned  input  1  selects zero-extension (1) or sign-extension (0) of sw_data to 32 bits.
REQ-012 uart_valid  input  1  one-cycle strobe; uart_data valid.
REQ-013 uart_data  input  8  received byte, zero-extended to 32 bits.
REQ-014 link_send  input  1  partner four-phase request; link_data stable while high.
REQ-015 link_data  input  32  partner word.
REQ-016 link_recv  output  1  four-phase acknowledge to partner.
REQ-017 overrun  output  3  sticky per-source drop flags, bit index = source code.

Function
REQ-018 Each source has one holding register (valid bit + 32-bit word).
REQ-019 A switch or UART strobe loads its empty holding register in the next cycle; a strobe while the register is full drops the data and sets the matching overrun bit.
REQ-020 Switch extension is applied at capture time using sw_unsigned sampled in the same cycle.
REQ-021 Link capture: link_send high with the holding register empty loads link_data and raises link_recv; link_recv stays high until link_send is sampled low, then falls; no new capture while link_recv is high.
REQ-022 Consume and capture of the same source in one cycle: the old word is delivered and the new word is kept; no overrun.
REQ-023 FSM states: IDLE, WAIT, ACK, DONE.
REQ-024 IDLE -> WAIT when in_req is sampled high.
REQ-025 WAIT -> ACK when any holding register is valid: the round-robin winner's word and code are registered into in_data/in_src, its valid bit is cleared, and the pointer moves to winner+1 (mod 3).
REQ-026 Round-robin order is 0, 1, 2; after reset the pointer is 0.
REQ-027 ACK asserts in_ack for exactly one cycle, then goes to DONE.
REQ-028 DONE -> IDLE when in_req is sampled low.
REQ-029 Latency: in_req high at edge N with data already held gives in_ack high in cycle N+2.
REQ-030 in_data and in_src hold their last values outside ACK.
REQ-031 overrun bits clear only on reset.

Reset
REQ-032 Reset (asynchronous, also mid-transfer) forces:
- state IDLE
- in_ack=0, in_data=0, in_src=0, in_on=0
- link_recv=0, overrun=0
- all holding registers invalid, pointer 0, timeout counter 0
REQ-033 A link_send still high after reset is captured again as a new transfer.

Configuration
REQ-034 Macro IN_ARB_TIMEOUT_EN defined: a counter runs in WAIT; after TIMEOUT_CYCLES cycles in WAIT with no valid source, the FSM goes to ACK with in_data=0 and in_src=3; the counter clears on leaving WAIT.
REQ-035 Macro IN_ARB_TIMEOUT_EN undefined: WAIT lasts indefinitely, the counter is absent, and in_src never equals 3.

Structure
REQ-036 Package in_arb_pkg holds the FSM state enum, the source code constants (SRC_SW, SRC_UART, SRC_LINK, SRC_TIMEOUT) and the 32-bit data width constant.
REQ-037 Sub-module rr_pick3 computes the winner from the three valid bits and the pointer (combinational).

Verification
REQ-038 After reset, sw_data=16'hFFFE, sw_unsigned=0, pulse, then in_req -> in_ack at +2 with in_data=32'hFFFFFFFE, in_src=0; repeat with sw_unsigned=1 -> in_data=32'h0000FFFE.
REQ-039 UART 8'h41, switch 16'h0005 and link 32'hDEADBEEF all held, three back-to-back IN requests -> in_src sequence 0, 1, 2, and overrun stays 0.
REQ-040 Two uart_valid strobes (8'h11, then 8'h22) with no IN between them -> overrun=3'b010; next IN returns 32'h00000011.
REQ-041 Link: link_send high with 32'h12345678 -> link_recv rises; link_send low -> link_recv falls; IN returns the word with in_src=2.
REQ-042 With IN_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: in_req with no data -> in_ack after the timeout with in_data=0, in_src=3; without the macro, no in_ack after 1000 cycles and in_on stays 1.
REQ-043 Reset asserted in state WAIT while link_recv is high -> all outputs return to reset values immediately; link_send still high after reset is recaptured.

Source files
------------

// File: rtl/in_arb_pkg.sv
// Shared types and constants for the CPU IN-port arbiter: FSM states,
// source codes and the delivered word width.
package in_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SRC_SW      = 2'd0;
  localparam logic [1:0] SRC_UART    = 2'd1;
  localparam logic [1:0] SRC_LINK    = 2'd2;
  localparam logic [1:0] SRC_TIMEOUT = 2'd3;

  // Successor in the round-robin ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] src);
    return (src == SRC_LINK) ? SRC_SW : src + 2'd1;
  endfunction

  function automatic logic [DATA_W-1:0] sw_extend(input logic [15:0] d, input logic is_unsigned);
    return is_unsigned ? {16'h0000, d} : {{16{d[15]}}, d};
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin pick: first valid source at or after the pointer,
// searching in ring order. Purely combinational.
module rr_pick3
  import in_arb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] winner
);

  logic [1:0] cand1;
  logic [1:0] cand2;

  // NOTE: every output of a combinational block gets a default before any
  // branch, otherwise the uncovered paths infer latches.
  always_comb begin
    cand1  = rr_next(ptr);
    cand2  = rr_next(cand1);
    winner = ptr;
    if (valid[ptr])        winner = ptr;
    else if (valid[cand1]) winner = cand1;
    else if (valid[cand2]) winner = cand2;
  end

  assign any = |valid;

endmodule

// File: rtl/in_port_arbiter.sv
// CPU IN-port arbiter: holds one word per source and hands them to the CPU in
// round-robin order. Define IN_ARB_TIMEOUT_EN to enable the WAIT timeout.
module in_port_arbiter
  import in_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_req,
  output logic              in_ack,
  output logic [DATA_W-1:0] in_data,
  output logic [1:0]        in_src,
  output logic              in_on,
  input  logic              sw_pulse,
  input  logic [15:0]       sw_data,
  input  logic              sw_unsigned,
  input  logic              uart_valid,
  input  logic [7:0]        uart_data,
  input  logic              link_send,
  input  logic [DATA_W-1:0] link_data,
  output logic              link_recv,
  output logic [2:0]        overrun
);

  state_t            state;
  state_t            state_next;
  logic [2:0]        valid;
  logic [2:0]        load;
  logic [2:0]        take_src;
  logic [DATA_W-1:0] hold [3];
  logic [1:0]        ptr;
  logic [1:0]        winner;
  logic              any_valid;
  logic              take;
  logic              timeout;

  rr_pick3 u_pick (
    .valid  (valid),
    .ptr    (ptr),
    .any    (any_valid),
    .winner (winner)
  );

  assign take     = (state == WAIT) && any_valid;
  assign take_src = take ? (3'b001 << winner) : 3'b000;

  // A register being consumed this cycle counts as empty, so back-to-back
  // consume and capture keeps the new word without an overrun.
  assign load[SRC_SW]   = sw_pulse   && (!valid[SRC_SW]   || take_src[SRC_SW]);
  assign load[SRC_UART] = uart_valid && (!valid[SRC_UART] || take_src[SRC_UART]);
  assign load[SRC_LINK] = link_send && !link_recv &&
                          (!valid[SRC_LINK] || take_src[SRC_LINK]);

`ifdef IN_ARB_TIMEOUT_EN
  logic [23:0] wait_cnt;

  assign timeout = (state == WAIT) && !any_valid &&
                   (wait_cnt == 24'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                     wait_cnt <= '0;
    else if (state == WAIT && state_next == WAIT)  wait_cnt <= wait_cnt + 24'd1;
    else                                           wait_cnt <= '0;
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign timeout               = 1'b0;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // NOTE: clocked state is written with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_req) state_next = WAIT;
      WAIT:    if (any_valid || timeout) state_next = ACK;
      ACK:     state_next = DONE;
      DONE:    if (!in_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ack = (state == ACK);
    in_on  = (state == WAIT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_data <= '0;
      in_src  <= SRC_SW;
      ptr     <= SRC_SW;
    end else if (take) begin
      in_data <= hold[winner];
      in_src  <= winner;
      ptr     <= rr_next(winner);
    end else if (timeout) begin
      in_data <= '0;
      in_src  <= SRC_TIMEOUT;
    end
  end

  // The link is flow-controlled by its handshake and can never drop a word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid     <= '0;
      overrun   <= '0;
      link_recv <= 1'b0;
    end else begin
      valid   <= load | (valid & ~take_src);
      overrun <= overrun | {1'b0, uart_valid && !load[SRC_UART], sw_pulse && !load[SRC_SW]};
      if (load[SRC_LINK])  link_recv <= 1'b1;
      else if (!link_send) link_recv <= 1'b0;
    end
  end

  // NOTE: the data words carry no reset; the valid bits guard them, and
  // leaving them out keeps the storage free of reset fan-out.
  always_ff @(posedge clock) begin
    if (load[SRC_SW])   hold[SRC_SW]   <= sw_extend(sw_data, sw_unsigned);
    if (load[SRC_UART]) hold[SRC_UART] <= {24'h000000, uart_data};
    if (load[SRC_LINK]) hold[SRC_LINK] <= link_data;
  end

endmodule

// File: tb/tb_in_port_arbiter.sv
// Directed bench for in_port_arbiter: a cycle-by-cycle vector table plus
// hand-written timeout and mid-transfer reset sequences.
module tb_in_port_arbiter;
  import in_arb_pkg::*;

`ifdef IN_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 1000000;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_req = 1'b0;
  logic        in_ack;
  logic [31:0] in_data;
  logic [1:0]  in_src;
  logic        in_on;
  logic        sw_pulse = 1'b0;
  logic [15:0] sw_data = '0;
  logic        sw_unsigned = 1'b0;
  logic        uart_valid = 1'b0;
  logic [7:0]  uart_data = '0;
  logic        link_send = 1'b0;
  logic [31:0] link_data = '0;
  logic        link_recv;
  logic [2:0]  overrun;

  int n_cmp = 0;
  int n_err = 0;

  in_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_req      (in_req),
    .in_ack      (in_ack),
    .in_data     (in_data),
    .in_src      (in_src),
    .in_on       (in_on),
    .sw_pulse    (sw_pulse),
    .sw_data     (sw_data),
    .sw_unsigned (sw_unsigned),
    .uart_valid  (uart_valid),
    .uart_data   (uart_data),
    .link_send   (link_send),
    .link_data   (link_data),
    .link_recv   (link_recv),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sp;
    logic [15:0] sd;
    logic        su;
    logic        uv;
    logic [7:0]  ud;
    logic        ls;
    logic [31:0] ld;
    logic        rq;
    logic        ack;
    logic [31:0] data;
    logic [1:0]  src;
    logic        on;
    logic        recv;
    logic [2:0]  ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic sp, input logic [15:0] sd, input logic su,
                              input logic uv, input logic [7:0] ud,
                              input logic ls, input logic [31:0] ld, input logic rq,
                              input logic ack, input logic [31:0] data, input logic [1:0] src,
                              input logic on, input logic recv, input logic [2:0] ov);
    vec_t v;
    v.sp = sp; v.sd = sd; v.su = su; v.uv = uv; v.ud = ud; v.ls = ls; v.ld = ld; v.rq = rq;
    v.ack = ack; v.data = data; v.src = src; v.on = on; v.recv = recv; v.ov = ov;
    return v;
  endfunction

  function automatic vec_t req(input logic rq, input logic ack, input logic [31:0] data,
                               input logic [1:0] src, input logic on, input logic [2:0] ov);
    return mk(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 32'h0, rq, ack, data, src, on, 1'b0, ov);
  endfunction

  function automatic logic [63:0] outs();
    return {24'h0, in_ack, in_data, in_src, in_on, link_recv, overrun};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // One IN transfer with data already held: ack must appear two edges after req.
  task automatic in_xfer(input string name, input logic [31:0] exp_data, input logic [1:0] exp_src);
    int n = 0;
    bit got = 1'b0;
    in_req = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      cycle();
      n++;
      got = in_ack;
    end
    check({name, "_latency"}, 64'(got ? n : -1), 64'd2);
    check({name, "_word"}, {30'h0, in_src, in_data}, {30'h0, exp_src, exp_data});
    in_req = 1'b0;
    repeat (3) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Three sources loaded together, then drained in round-robin order.
    tbl.push_back(mk(1, 16'h0005, 0, 1, 8'h41, 1, 32'hDEADBEEF, 0, 0, 32'h0, 0, 0, 1, 3'b000));
    tbl.push_back(req(1, 0, 32'h0,        0, 1, 3'b000));
    tbl.push_back(req(1, 1, 32'h00000005, 0, 0, 3'b000));
    tbl.push_back(req(1, 0, 32'h00000005, 0, 0, 3'b000));
    tbl.push_back(req(0, 0, 32'h00000005, 0, 0, 3'b000));
    tbl.push_back(req(1, 0, 32'h00000005, 0, 1, 3'b000));
    tbl.push_back(req(1, 1, 32'h00000041, 1, 0, 3'b000));
    tbl.push_back(req(1, 0, 32'h00000041, 1, 0, 3'b000));
    tbl.push_back(req(0, 0, 32'h00000041, 1, 0, 3'b000));
    tbl.push_back(req(1, 0, 32'h00000041, 1, 1, 3'b000));
    tbl.push_back(req(1, 1, 32'hDEADBEEF, 2, 0, 3'b000));
    tbl.push_back(req(1, 0, 32'hDEADBEEF, 2, 0, 3'b000));
    tbl.push_back(req(0, 0, 32'hDEADBEEF, 2, 0, 3'b000));
    // Switch sign extension, then zero extension.
    tbl.push_back(mk(1, 16'hFFFE, 0, 0, 8'h0, 0, 32'h0, 0, 0, 32'hDEADBEEF, 2, 0, 0, 3'b000));
    tbl.push_back(req(1, 0, 32'hDEADBEEF, 2, 1, 3'b000));
    tbl.push_back(req(1, 1, 32'hFFFFFFFE, 0, 0, 3'b000));
    tbl.push_back(req(1, 0, 32'hFFFFFFFE, 0, 0, 3'b000));
    tbl.push_back(req(0, 0, 32'hFFFFFFFE, 0, 0, 3'b000));
    tbl.push_back(mk(1, 16'hFFFE, 1, 0, 8'h0, 0, 32'h0, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 3'b000));
    tbl.push_back(req(1, 0, 32'hFFFFFFFE, 0, 1, 3'b000));
    tbl.push_back(req(1, 1, 32'h0000FFFE, 0, 0, 3'b000));
    tbl.push_back(req(1, 0, 32'h0000FFFE, 0, 0, 3'b000));
    tbl.push_back(req(0, 0, 32'h0000FFFE, 0, 0, 3'b000));
    // Second UART strobe with the register full: drop and flag.
    tbl.push_back(mk(0, 16'h0, 0, 1, 8'h11, 0, 32'h0, 0, 0, 32'h0000FFFE, 0, 0, 0, 3'b000));
    tbl.push_back(mk(0, 16'h0, 0, 1, 8'h22, 0, 32'h0, 0, 0, 32'h0000FFFE, 0, 0, 0, 3'b010));
    tbl.push_back(req(1, 0, 32'h0000FFFE, 0, 1, 3'b010));
    tbl.push_back(req(1, 1, 32'h00000011, 1, 0, 3'b010));
    tbl.push_back(req(1, 0, 32'h00000011, 1, 0, 3'b010));
    tbl.push_back(req(0, 0, 32'h00000011, 1, 0, 3'b010));
    // Link four-phase handshake.
    tbl.push_back(mk(0, 16'h0, 0, 0, 8'h0, 1, 32'h12345678, 0, 0, 32'h00000011, 1, 0, 1, 3'b010));
    tbl.push_back(mk(0, 16'h0, 0, 0, 8'h0, 1, 32'h12345678, 0, 0, 32'h00000011, 1, 0, 1, 3'b010));
    tbl.push_back(req(0, 0, 32'h00000011, 1, 0, 3'b010));
    tbl.push_back(req(1, 0, 32'h00000011, 1, 1, 3'b010));
    tbl.push_back(req(1, 1, 32'h12345678, 2, 0, 3'b010));
    tbl.push_back(req(1, 0, 32'h12345678, 2, 0, 3'b010));
    tbl.push_back(req(0, 0, 32'h12345678, 2, 0, 3'b010));
    // Switch captured in the same cycle its old word is consumed.
    tbl.push_back(mk(1, 16'h0001, 1, 0, 8'h0, 0, 32'h0, 0, 0, 32'h12345678, 2, 0, 0, 3'b010));
    tbl.push_back(req(1, 0, 32'h12345678, 2, 1, 3'b010));
    tbl.push_back(mk(1, 16'h0002, 1, 0, 8'h0, 0, 32'h0, 1, 1, 32'h00000001, 0, 0, 0, 3'b010));
    tbl.push_back(req(1, 0, 32'h00000001, 0, 0, 3'b010));
    tbl.push_back(req(0, 0, 32'h00000001, 0, 0, 3'b010));
    tbl.push_back(req(1, 0, 32'h00000001, 0, 1, 3'b010));
    tbl.push_back(req(1, 1, 32'h00000002, 0, 0, 3'b010));
    tbl.push_back(req(1, 0, 32'h00000002, 0, 0, 3'b010));
    tbl.push_back(req(0, 0, 32'h00000002, 0, 0, 3'b010));

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_state", outs(), 64'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      sw_pulse = tbl[i].sp; sw_data = tbl[i].sd; sw_unsigned = tbl[i].su;
      uart_valid = tbl[i].uv; uart_data = tbl[i].ud;
      link_send = tbl[i].ls; link_data = tbl[i].ld; in_req = tbl[i].rq;
      cycle();
      check($sformatf("vec%0d", i), outs(),
            {24'h0, tbl[i].ack, tbl[i].data, tbl[i].src, tbl[i].on, tbl[i].recv, tbl[i].ov});
    end
    sw_pulse = 1'b0; uart_valid = 1'b0; link_send = 1'b0; in_req = 1'b0;
    cycle();

`ifdef IN_ARB_TIMEOUT_EN
    begin
      int n = 0;
      bit got = 1'b0;
      in_req = 1'b1;
      for (int c = 0; c < 50 && !got; c++) begin
        cycle();
        n++;
        got = in_ack;
      end
      check("timeout_latency", 64'(got ? n : -1), 64'd9);
      check("timeout_word", {30'h0, in_src, in_data}, {30'h0, 2'd3, 32'h0});
    end
`else
    begin
      bit saw_ack = 1'b0;
      bit saw_src3 = 1'b0;
      bit on_dropped = 1'b0;
      in_req = 1'b1;
      cycle();
      for (int c = 0; c < 1000; c++) begin
        cycle();
        if (in_ack) saw_ack = 1'b1;
        if (in_src == 2'd3) saw_src3 = 1'b1;
        if (!in_on) on_dropped = 1'b1;
      end
      check("no_timeout_ack", 64'(saw_ack), 64'd0);
      check("no_timeout_on", 64'({on_dropped, saw_src3}), 64'd0);
    end
`endif

    // Get into WAIT with a link word just captured, then reset mid-transfer.
    in_req = 1'b0;
    repeat (3) cycle();
    in_req = 1'b1;
    cycle();
    link_send = 1'b1;
    link_data = 32'hAAAA5555;
    cycle();
    check("pre_reset_wait", 64'({in_on, link_recv, overrun}), 64'({1'b1, 1'b1, 3'b010}));
    in_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", outs(), 64'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cycle();
    check("link_recapture", 64'(link_recv), 64'd1);
    link_send = 1'b0;
    cycle();
    check("link_release", 64'(link_recv), 64'd0);
    in_xfer("post_reset_link", 32'hAAAA5555, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
